// File: rtl/sdspi_sweep_ctrl.sv
// Sweeps n_blocks x sclk_speed x cmd18; per point resets, starts and times sdspi_system.
// Latency: first uut_start RST_CYCLES+1 cycles after go; a result is valid the cycle after finish/timeout.
// Backpressure: REPORT holds res_valid and every res_* field until res_ready; only abort withdraws it.
module sdspi_sweep_ctrl #(
  parameter int              N_BLOCK_SIZE    = 32,
  parameter int              SCLK_SPEED_SIZE = 5,
  parameter int              CMD18_SIZE      = 1,
  parameter int              CNT_W           = 32,
  parameter int              RST_CYCLES      = 16,
  parameter longint unsigned TIMEOUT_CYCLES  = 64'd2147483648
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       abort,
  input  logic [N_BLOCK_SIZE-1:0]    nb_min,
  input  logic [N_BLOCK_SIZE-1:0]    nb_max,
  input  logic [SCLK_SPEED_SIZE-1:0] speed_min,
  input  logic [SCLK_SPEED_SIZE-1:0] speed_max,
  input  logic                       cmd18_en,
  output logic                       uut_ctrl_mux,
  output logic                       uut_rst,
  output logic                       uut_start,
  output logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
  output logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
  output logic [CMD18_SIZE-1:0]      uut_cmd18,
  input  logic                       uut_finish,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N_BLOCK_SIZE-1:0]    res_n_blocks,
  output logic [SCLK_SPEED_SIZE-1:0] res_sclk_speed,
  output logic [CMD18_SIZE-1:0]      res_cmd18,
  output logic [CNT_W-1:0]           res_cycles,
  output logic                       res_timeout,
  output logic                       busy,
  output logic                       done
);

  // RESET dwell counter only needs to reach RST_CYCLES-1.
  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_START,
    ST_RUN,
    ST_REPORT,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Bounds latched at go so the sweep is immune to input changes mid-run.
  logic [N_BLOCK_SIZE-1:0]    nb_max_q;
  logic [SCLK_SPEED_SIZE-1:0] speed_min_q;
  logic [SCLK_SPEED_SIZE-1:0] speed_max_q;
  logic                       cmd18_en_q;

  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_inc;

  logic [N_BLOCK_SIZE-1:0]    nb_eff;
  logic [N_BLOCK_SIZE-1:0]    nb_shift;
  logic [N_BLOCK_SIZE-1:0]    nb_adv;
  logic [SCLK_SPEED_SIZE-1:0] sp_adv;
  logic [CMD18_SIZE-1:0]      c18_adv;
  logic                       pt_more;
  logic                       range_empty;
  logic                       run_end;

  logic uut_rst_d;
  logic uut_ctrl_mux_d;
  logic uut_start_d;
  logic res_valid_d;
  logic busy_d;
  logic done_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, point advance and the next value of every registered control output.
  always_comb begin
    state_nxt   = state;
    nb_eff      = (nb_min == '0) ? N_BLOCK_SIZE'(1) : nb_min;
    range_empty = (nb_eff > nb_max) || (speed_min > speed_max);
    run_cnt_inc = run_cnt + CNT_W'(1);
    run_end     = uut_finish || (run_cnt_inc == TMO);
    nb_shift    = {uut_n_blocks[N_BLOCK_SIZE-2:0], 1'b0};
    nb_adv      = uut_n_blocks;
    sp_adv      = uut_sclk_speed;
    c18_adv     = uut_cmd18;
    pt_more     = 1'b0;

    // cmd18 is the innermost axis, n_blocks the outermost.
    if (cmd18_en_q && (uut_cmd18 == '0)) begin
      c18_adv = CMD18_SIZE'(1);
      pt_more = 1'b1;
    end else begin
      c18_adv = '0;
      if (uut_sclk_speed < speed_max_q) begin
        sp_adv  = uut_sclk_speed + SCLK_SPEED_SIZE'(1);
        pt_more = 1'b1;
      end else begin
        sp_adv  = speed_min_q;
        nb_adv  = nb_shift;
        // A set MSB means the doubling falls off the top of the register.
        pt_more = !uut_n_blocks[N_BLOCK_SIZE-1] && (nb_shift <= nb_max_q);
      end
    end

    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (go) state_nxt = range_empty ? ST_DONE : ST_RESET;
        ST_RESET:  if (rst_cnt == RC_LAST) state_nxt = ST_START;
        ST_START:  state_nxt = ST_RUN;
        ST_RUN:    if (run_end) state_nxt = ST_REPORT;
        ST_REPORT: if (res_ready) state_nxt = ST_NEXT;
        ST_NEXT:   state_nxt = pt_more ? ST_RESET : ST_DONE;
        ST_DONE:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    uut_rst_d      = !((state_nxt == ST_START) || (state_nxt == ST_RUN));
    uut_ctrl_mux_d = (state_nxt == ST_RESET) || (state_nxt == ST_START) || (state_nxt == ST_RUN);
    uut_start_d    = (state_nxt == ST_START);
    res_valid_d    = (state_nxt == ST_REPORT);
    busy_d         = (state_nxt != ST_IDLE);
    done_d         = (state_nxt == ST_DONE);
  end

  // Registered control outputs; the engine is held in reset out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uut_rst      <= 1'b1;
      uut_ctrl_mux <= 1'b0;
      uut_start    <= 1'b0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      uut_rst      <= uut_rst_d;
      uut_ctrl_mux <= uut_ctrl_mux_d;
      uut_start    <= uut_start_d;
      res_valid    <= res_valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Bounds, current point, RESET/RUN counters and the captured result record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nb_max_q       <= '0;
      speed_min_q    <= '0;
      speed_max_q    <= '0;
      cmd18_en_q     <= 1'b0;
      uut_n_blocks   <= '0;
      uut_sclk_speed <= '0;
      uut_cmd18      <= '0;
      rst_cnt        <= '0;
      run_cnt        <= '0;
      res_n_blocks   <= '0;
      res_sclk_speed <= '0;
      res_cmd18      <= '0;
      res_cycles     <= '0;
      res_timeout    <= 1'b0;
    end else begin
      // Counts RESET cycles; any other state rearms it for the next entry.
      rst_cnt <= (state == ST_RESET) ? rst_cnt + RC_W'(1) : '0;

      if (!abort) begin
        case (state)
          ST_IDLE: begin
            if (go) begin
              nb_max_q       <= nb_max;
              speed_min_q    <= speed_min;
              speed_max_q    <= speed_max;
              cmd18_en_q     <= cmd18_en;
              uut_n_blocks   <= nb_eff;
              uut_sclk_speed <= speed_min;
              uut_cmd18      <= '0;
            end
          end
          ST_START: begin
            run_cnt <= '0;
          end
          ST_RUN: begin
            run_cnt <= run_cnt_inc;
            if (run_end) begin
              // Finish wins over the limit when both land on the same cycle.
              res_cycles     <= uut_finish ? run_cnt_inc : TMO;
              res_timeout    <= !uut_finish;
              res_n_blocks   <= uut_n_blocks;
              res_sclk_speed <= uut_sclk_speed;
              res_cmd18      <= uut_cmd18;
            end
          end
          ST_NEXT: begin
            // Leave the last point in place when the sweep ends.
            if (pt_more) begin
              uut_n_blocks   <= nb_adv;
              uut_sclk_speed <= sp_adv;
              uut_cmd18      <= c18_adv;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
